// File: rtl/operand_fetch.sv
// operand_fetch: LEGv8 ID-side operand stage feeding the ID/EX register.
// Drives the regfile read addresses, merges same-cycle writeback bypass,
// forces XZR operands to zero and inserts one bubble per load-use pair.
// Optional build macro OPFETCH_STATS_EN adds saturating stall/flush counters.
module operand_fetch #(
  parameter int unsigned WIDTH    = 64,
  parameter int unsigned ZERO_REG = 31
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_d,
  input  logic [31:0]      instr_d,
  input  logic [63:0]      pc_d,
  input  logic             reg2loc_d,
  input  logic             memread_d,
  output logic [4:0]       ra1,
  output logic [4:0]       ra2,
  input  logic [WIDTH-1:0] rd1,
  input  logic [WIDTH-1:0] rd2,
  input  logic             wb_we,
  input  logic [4:0]       wb_wa,
  input  logic [WIDTH-1:0] wb_wd,
  input  logic             flush_e,
  output logic             stall_d,
  output logic             valid_e,
  output logic [31:0]      instr_e,
  output logic [63:0]      pc_e,
  output logic [WIDTH-1:0] opa_e,
  output logic [WIDTH-1:0] opb_e,
  output logic [4:0]       rd_e,
  output logic             memread_e
`ifdef OPFETCH_STATS_EN
  ,
  output logic [31:0]      stall_count,
  output logic [31:0]      flush_count
`endif
);

  localparam logic [4:0] ZR = 5'(ZERO_REG);

  logic             valid_e_q, valid_e_d;
  logic [31:0]      instr_e_q, instr_e_d;
  logic [63:0]      pc_e_q, pc_e_d;
  logic [WIDTH-1:0] opa_e_q, opa_e_d;
  logic [WIDTH-1:0] opb_e_q, opb_e_d;
  logic [4:0]       rd_e_q, rd_e_d;
  logic             memread_e_q, memread_e_d;

  logic [WIDTH-1:0] opa_next, opb_next;
  logic             hz;

  // Source register addresses straight from the ID instruction
  assign ra1 = instr_d[9:5];
  assign ra2 = reg2loc_d ? instr_d[4:0] : instr_d[20:16];

  // Operand select: XZR reads zero, else writeback bypass, else regfile
  always_comb begin
    opa_next = rd1;
    opb_next = rd2;
    if (ra1 == ZR) begin
      opa_next = '0;
    end else if (wb_we && (wb_wa == ra1)) begin
      opa_next = wb_wd;
    end
    if (ra2 == ZR) begin
      opb_next = '0;
    end else if (wb_we && (wb_wa == ra2)) begin
      opb_next = wb_wd;
    end
  end

  // Load-use hazard against the load currently in EX
  assign hz = valid_d && valid_e_q && memread_e_q && (rd_e_q != ZR) &&
              ((rd_e_q == ra1) || (rd_e_q == ra2));
  assign stall_d = hz && !flush_e;

  // ID/EX next state: flush beats bubble beats normal advance
  always_comb begin
    valid_e_d   = valid_e_q;
    instr_e_d   = instr_e_q;
    pc_e_d      = pc_e_q;
    opa_e_d     = opa_e_q;
    opb_e_d     = opb_e_q;
    rd_e_d      = rd_e_q;
    memread_e_d = memread_e_q;
    if (flush_e) begin
      valid_e_d   = 1'b0;
      memread_e_d = 1'b0;
    end else if (hz) begin
      valid_e_d   = 1'b0;
      memread_e_d = 1'b0;
      rd_e_d      = ZR;
    end else begin
      valid_e_d   = valid_d;
      memread_e_d = memread_d && valid_d;
      instr_e_d   = instr_d;
      pc_e_d      = pc_d;
      opa_e_d     = opa_next;
      opb_e_d     = opb_next;
      rd_e_d      = instr_d[4:0];
    end
  end

  // ID/EX pipeline register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_e_q   <= 1'b0;
      instr_e_q   <= '0;
      pc_e_q      <= '0;
      opa_e_q     <= '0;
      opb_e_q     <= '0;
      rd_e_q      <= ZR;
      memread_e_q <= 1'b0;
    end else begin
      valid_e_q   <= valid_e_d;
      instr_e_q   <= instr_e_d;
      pc_e_q      <= pc_e_d;
      opa_e_q     <= opa_e_d;
      opb_e_q     <= opb_e_d;
      rd_e_q      <= rd_e_d;
      memread_e_q <= memread_e_d;
    end
  end

  assign valid_e   = valid_e_q;
  assign instr_e   = instr_e_q;
  assign pc_e      = pc_e_q;
  assign opa_e     = opa_e_q;
  assign opb_e     = opb_e_q;
  assign rd_e      = rd_e_q;
  assign memread_e = memread_e_q;

`ifdef OPFETCH_STATS_EN
  logic [31:0] stall_count_q, stall_count_d;
  logic [31:0] flush_count_q, flush_count_d;

  // Saturating event counters
  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (stall_d && (stall_count_q != 32'hFFFF_FFFF)) begin
      stall_count_d = stall_count_q + 32'd1;
    end
    if (flush_e && (flush_count_q != 32'hFFFF_FFFF)) begin
      flush_count_d = flush_count_q + 32'd1;
    end
  end

  // Counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;
`endif

endmodule

// File: tb/tb_operand_fetch.sv
// Testbench for operand_fetch: directed cases then randomized traffic,
// checked through an expected-issue queue drained by a monitor.
module tb_operand_fetch;

  localparam int unsigned WIDTH = 64;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             valid_d = 1'b0;
  logic [31:0]      instr_d = '0;
  logic [63:0]      pc_d = '0;
  logic             reg2loc_d = 1'b0;
  logic             memread_d = 1'b0;
  logic [4:0]       ra1, ra2;
  logic [WIDTH-1:0] rd1 = '0, rd2 = '0;
  logic             wb_we = 1'b0;
  logic [4:0]       wb_wa = '0;
  logic [WIDTH-1:0] wb_wd = '0;
  logic             flush_e = 1'b0;
  logic             stall_d, valid_e, memread_e;
  logic [31:0]      instr_e;
  logic [63:0]      pc_e;
  logic [WIDTH-1:0] opa_e, opb_e;
  logic [4:0]       rd_e;
`ifdef OPFETCH_STATS_EN
  logic [31:0]      stall_count, flush_count;
`endif

  operand_fetch #(.WIDTH(WIDTH), .ZERO_REG(31)) dut (
    .clk(clk), .reset(reset), .valid_d(valid_d), .instr_d(instr_d), .pc_d(pc_d),
    .reg2loc_d(reg2loc_d), .memread_d(memread_d), .ra1(ra1), .ra2(ra2),
    .rd1(rd1), .rd2(rd2), .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd),
    .flush_e(flush_e), .stall_d(stall_d), .valid_e(valid_e), .instr_e(instr_e),
    .pc_e(pc_e), .opa_e(opa_e), .opb_e(opb_e), .rd_e(rd_e), .memread_e(memread_e)
`ifdef OPFETCH_STATS_EN
    , .stall_count(stall_count), .flush_count(flush_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]      instr;
    logic [63:0]      pc;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [4:0]       rd;
    logic             memread;
  } issue_t;

  issue_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model of what currently sits in EX
  bit       m_valid = 0;
  bit       m_load  = 0;
  bit [4:0] m_dest  = 31;
  int       m_stalls = 0;
  int       m_flushes = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural operand value seen by an instruction reading register r
  function automatic logic [63:0] operand(input int r, input logic [63:0] file_val,
                                          input bit we, input int wa, input logic [63:0] wd);
    if (r == 31) return 64'd0;
    if (we && wa == r) return wd;
    return file_val;
  endfunction

  // Drive one ID cycle, check combinational outputs, advance the model
  task automatic step(input bit v, input logic [31:0] ins, input logic [63:0] pc,
                      input bit r2l, input bit ld, input logic [63:0] f1, input logic [63:0] f2,
                      input bit we, input logic [4:0] wa, input logic [63:0] wd,
                      input bit fl, output bit stalled);
    int s1, s2;
    bit load_use;
    issue_t e;
    @(negedge clk);
    valid_d = v; instr_d = ins; pc_d = pc; reg2loc_d = r2l; memread_d = ld;
    rd1 = f1; rd2 = f2; wb_we = we; wb_wa = wa; wb_wd = wd; flush_e = fl;
    #1;
    s1 = int'(ins[9:5]);
    s2 = r2l ? int'(ins[4:0]) : int'(ins[20:16]);
    load_use = v && m_valid && m_load && m_dest != 5'd31 &&
               (int'(m_dest) == s1 || int'(m_dest) == s2);
    stalled = load_use && !fl;
    check("ra1", 64'(ra1), 64'(s1));
    check("ra2", 64'(ra2), 64'(s2));
    check("stall_d", 64'(stall_d), 64'(stalled));
    if (stalled) m_stalls++;
    if (fl) m_flushes++;
    if (fl) begin
      m_valid = 0; m_load = 0;
    end else if (load_use) begin
      m_valid = 0; m_load = 0; m_dest = 31;
    end else begin
      m_valid = v; m_load = v && ld; m_dest = ins[4:0];
      if (v) begin
        e.instr = ins; e.pc = pc; e.rd = ins[4:0]; e.memread = ld;
        e.opa = operand(s1, f1, we, int'(wa), wd);
        e.opb = operand(s2, f2, we, int'(wa), wd);
        exp_q.push_back(e);
      end
    end
  endtask

  // Asynchronous reset pulse in the middle of a cycle
  task automatic do_reset();
    @(negedge clk);
    valid_d = 0; flush_e = 0; wb_we = 0; memread_d = 0;
    #2 reset = 1'b1;
    #1;
    check("rst valid_e", 64'(valid_e), 64'd0);
    check("rst memread_e", 64'(memread_e), 64'd0);
    check("rst rd_e", 64'(rd_e), 64'd31);
    check("rst instr_e", 64'(instr_e), 64'd0);
    check("rst pc_e", pc_e, 64'd0);
    check("rst opa_e", opa_e, 64'd0);
    check("rst opb_e", opb_e, 64'd0);
    check("rst stall_d", 64'(stall_d), 64'd0);
`ifdef OPFETCH_STATS_EN
    check("rst stall_count", 64'(stall_count), 64'd0);
    check("rst flush_count", 64'(flush_count), 64'd0);
`endif
    m_valid = 0; m_load = 0; m_dest = 31; m_stalls = 0; m_flushes = 0;
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: every valid EX presentation must match the oldest expected issue
  initial begin
    issue_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!reset && valid_e) begin
        if (exp_q.size() == 0) begin
          check("unexpected issue", 64'(valid_e), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("instr_e", 64'(instr_e), 64'(e.instr));
          check("pc_e", pc_e, e.pc);
          check("opa_e", opa_e, e.opa);
          check("opb_e", opb_e, e.opb);
          check("rd_e", 64'(rd_e), 64'(e.rd));
          check("memread_e", 64'(memread_e), 64'(e.memread));
        end
      end
    end
  end

  function automatic logic [31:0] rtype(input int rm, input int rn, input int rd);
    return {11'b10001011000, 5'(rm), 6'd0, 5'(rn), 5'(rd)};
  endfunction

  function automatic logic [31:0] ldur(input int rn, input int rt);
    return {11'b11111000010, 9'd0, 2'b00, 5'(rn), 5'(rt)};
  endfunction

  function automatic logic [4:0] pick_reg();
    int k = int'($urandom_range(0, 5));
    return (k == 5) ? 5'd31 : 5'(k);
  endfunction

  initial begin
    bit st;
    logic [31:0] ins;
    logic [63:0] pc;
    bit v, r2l, ld;
    #12;
    do_reset();

    // ADD X3,X1,X2 with plain regfile data
    step(1, rtype(2, 1, 3), 64'h100, 0, 0, 64'd5, 64'd7, 0, 5'd0, 64'd0, 0, st);
    // Bypass into X4
    step(1, rtype(6, 4, 8), 64'h104, 0, 0, 64'd0, 64'd9, 1, 5'd4, 64'h0123456789ABCDEF, 0, st);
    // X31 never bypasses
    step(1, rtype(5, 31, 7), 64'h108, 0, 0, 64'd11, 64'd12, 1, 5'd31, 64'hFEDCBA9876543210, 0, st);
    // STUR-style second source via reg2loc
    step(1, 32'hF800_0000 | {22'd0, 5'd6, 5'd10}, 64'h10C, 1, 0, 64'd1, 64'd2, 1, 5'd10, 64'hAA, 0, st);
    // LDUR X9 then dependent ADD: one stall, then issue with bypassed X9
    step(1, ldur(2, 9), 64'h110, 0, 1, 64'd20, 64'd0, 0, 5'd0, 64'd0, 0, st);
    step(1, rtype(1, 9, 10), 64'h114, 0, 0, 64'd0, 64'd3, 0, 5'd0, 64'd0, 0, st);
    step(1, rtype(1, 9, 10), 64'h114, 0, 0, 64'd0, 64'd3, 1, 5'd9, 64'h5555, 0, st);
    // Load into X31 then reader of X31: no stall
    step(1, ldur(2, 31), 64'h118, 0, 1, 64'd20, 64'd0, 0, 5'd0, 64'd0, 0, st);
    step(1, rtype(1, 31, 10), 64'h11C, 0, 0, 64'd4, 64'd3, 0, 5'd0, 64'd0, 0, st);
    // Flush in the same cycle as a load-use hazard
    step(1, ldur(2, 9), 64'h120, 0, 1, 64'd20, 64'd0, 0, 5'd0, 64'd0, 0, st);
    step(1, rtype(9, 1, 12), 64'h124, 0, 0, 64'd0, 64'd0, 0, 5'd0, 64'd0, 1, st);
    step(1, rtype(2, 1, 3), 64'h200, 0, 0, 64'd5, 64'd7, 0, 5'd0, 64'd0, 0, st);
`ifdef OPFETCH_STATS_EN
    @(negedge clk);
    check("stall_count", 64'(stall_count), 64'(m_stalls));
    check("flush_count", 64'(flush_count), 64'(m_flushes));
`endif
    // Reset while EX holds a valid instruction
    step(1, rtype(2, 1, 3), 64'h300, 0, 0, 64'd5, 64'd7, 0, 5'd0, 64'd0, 0, st);
    do_reset();

    // Randomized traffic; IF/ID is held while stalled
    st = 0; v = 0; ins = '0; pc = '0; r2l = 0; ld = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!st) begin
        v   = ($urandom_range(0, 9) < 8);
        r2l = $urandom_range(0, 3) == 0;
        ld  = $urandom_range(0, 2) == 0;
        ins = {$urandom} & 32'hFFE0_FC00;
        ins = ins | {11'd0, pick_reg(), 6'd0, pick_reg(), pick_reg()};
        pc  = {$urandom, $urandom};
      end
      step(v, ins, pc, r2l, ld, {$urandom, $urandom}, {$urandom, $urandom},
           $urandom_range(0, 1) == 1, pick_reg(), {$urandom, $urandom},
           $urandom_range(0, 9) == 0, st);
    end
    step(0, 32'd0, 64'd0, 0, 0, 64'd0, 64'd0, 0, 5'd0, 64'd0, 0, st);
    @(negedge clk);
`ifdef OPFETCH_STATS_EN
    check("stall_count", 64'(stall_count), 64'(m_stalls));
    check("flush_count", 64'(flush_count), 64'(m_flushes));
`endif
    check("pending issues", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
